// File: rtl/lamp_dwell_timer.sv
// lamp_dwell_timer
// Times the dwell of each colour shown by a downstream cyclic lamp and
// produces a one-cycle `advance` step when the dwell expires. A latched
// pedestrian request is granted at the start of a RED phase and stretches
// that RED dwell by PED_EXTRA cycles. A non-one-hot lamp code raises a
// sticky fault and is timed with the plain RED limit.
module lamp_dwell_timer #(
    parameter int unsigned RED_TICKS    = 8,
    parameter int unsigned GREEN_TICKS  = 6,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned PED_EXTRA    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [0:2] light,
    input  logic       ped_req,
    output logic       advance,
    output logic       ped_ack,
    output logic       ped_pending,
    output logic       fault,
    output logic [3:0] count
);

    // Dwell limits, widened to 5 bits so limit-1 and the extended RED limit
    // compare without truncation.
    localparam logic [4:0] RED_LIM     = 5'(RED_TICKS);
    localparam logic [4:0] RED_EXT_LIM = 5'(RED_TICKS + PED_EXTRA);
    localparam logic [4:0] GREEN_LIM   = 5'(GREEN_TICKS);
    localparam logic [4:0] YELLOW_LIM  = 5'(YELLOW_TICKS);

    logic [3:0] count_q, count_d;
    logic       phase_start_q, phase_start_d;
    logic       pending_q, pending_d;
    logic       ack_q, ack_d;
    logic       fault_q, fault_d;
    logic       ext_q, ext_d;          // current RED dwell already extended

    logic       is_red, is_green, is_yellow, is_legal;
    logic       grant;
    logic [4:0] limit;
    logic       last_tick;

    // Decode the lamp code and select the dwell limit for this cycle.
    always_comb begin
        is_red    = (light == 3'b100);
        is_green  = (light == 3'b010);
        is_yellow = (light == 3'b001);
        is_legal  = is_red | is_green | is_yellow;

        // Grant only at a true RED phase start; an illegal code never extends.
        grant = ~reset & enable & phase_start_q & pending_q & is_red;

        if (is_green) begin
            limit = GREEN_LIM;
        end else if (is_yellow) begin
            limit = YELLOW_LIM;
        end else if (is_red && (ext_q || grant)) begin
            limit = RED_EXT_LIM;
        end else begin
            limit = RED_LIM;
        end

        // ">=" rather than "==" so a count left above a shorter limit (lamp
        // changed externally) still terminates the dwell instead of wrapping.
        last_tick = ({1'b0, count_q} >= (limit - 5'd1));
        advance   = ~reset & enable & last_tick;
    end

    // Next-state logic for the dwell counter, pedestrian latch and flags.
    always_comb begin
        count_d       = count_q;
        phase_start_d = phase_start_q;
        pending_d     = pending_q;
        ack_d         = 1'b0;
        fault_d       = fault_q;
        ext_d         = ext_q;

        if (reset) begin
            count_d       = 4'd0;
            phase_start_d = 1'b1;
            pending_d     = 1'b0;
            ack_d         = 1'b0;
            fault_d       = 1'b0;
            ext_d         = 1'b0;
        end else begin
            if (enable) begin
                count_d = advance ? 4'd0 : (count_q + 4'd1);
            end

            if (advance) begin
                phase_start_d = 1'b1;
            end else if (enable) begin
                phase_start_d = 1'b0;
            end

            // A new request in the grant cycle re-arms the latch.
            if (ped_req) begin
                pending_d = 1'b1;
            end else if (grant) begin
                pending_d = 1'b0;
            end

            ack_d = grant;

            if (advance) begin
                ext_d = 1'b0;
            end else if (grant) begin
                ext_d = 1'b1;
            end

            if (!is_legal) begin
                fault_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        count_q       <= count_d;
        phase_start_q <= phase_start_d;
        pending_q     <= pending_d;
        ack_q         <= ack_d;
        fault_q       <= fault_d;
        ext_q         <= ext_d;
    end

    assign count       = count_q;
    assign ped_pending = pending_q;
    assign ped_ack     = ack_q;
    assign fault       = fault_q;

endmodule
